seven_seg_scan_decoder: RTL



---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_to_hex.sv | 25 ++
 rtl/seven_seg_scan_decoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: glyph table, idle codes, scan sample type.
// Latency: none (package only).
// Backpressure: not applicable.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [7:0] AN_IDLE   = 8'hFF;

    // Active-low segment patterns, bit6=g .. bit0=a, indexed by hex value
    localparam logic [15:0][6:0] GLYPH = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
    } scan_t;

    localparam scan_t SCAN_IDLE = '{an: AN_IDLE, seg: SEG_BLANK};

endpackage

// File: rtl/seg7_to_hex.sv
// Reverse-maps an active-low seven-segment pattern to its hex value.
// Latency: combinational.
// Backpressure: none.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       legal,
    output logic       blank
);

    always_comb begin
        value = 4'd0;
        legal = 1'b0;
        blank = (seg == SEG_BLANK);
        for (int k = 0; k < 16; k++) begin
            if (seg == GLYPH[k]) begin
                value = 4'(k);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Samples a scanned 7-seg display (AN/hexdisp), debounces it and decodes each digit to hex.
// Latency: outputs update 2+STABLE_CYCLES edges after a pin change.
// Backpressure: none; free-running receiver, patterns shorter than STABLE_CYCLES are dropped.
module seven_seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                hexdisp,
    input  logic [7:0]                AN,
    input  logic                      clr_err,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic [NUM_DIGITS-1:0]     digit_blank,
    output logic                      frame_done,
    output logic                      anode_err,
    output logic                      decode_err
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    scan_t                       sync1_q;
    scan_t                       sync2_q;
    logic [CW-1:0]               cnt_q;
    logic                        captured_q;
    logic [NUM_DIGITS-1:0]       seen_q;
    logic [NUM_DIGITS-1:0][3:0]  digits_q;

    logic                        changed;
    logic                        capture;
    logic [3:0]                  lit_cnt;
    logic [IW-1:0]               lit_idx;
    logic                        one_lit;
    logic                        multi_lit;
    logic [3:0]                  dec_value;
    logic                        dec_legal;
    logic                        dec_blank;
    logic                        dec_bad;
    logic [NUM_DIGITS-1:0]       seen_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= SCAN_IDLE;
            sync2_q <= SCAN_IDLE;
        end else begin
            sync1_q <= '{an: AN, seg: hexdisp};
            sync2_q <= sync1_q;
        end
    end

    // Change is detected one stage early so the counter reads 0 on the first cycle S shows a new pattern
    assign changed = (sync1_q != sync2_q);
    assign capture = (cnt_q == CNT_MAX) && !captured_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            captured_q <= 1'b0;
        end else if (changed) begin
            cnt_q      <= '0;
            captured_q <= 1'b0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (capture) begin
                captured_q <= 1'b1;
            end
        end
    end

    always_comb begin
        lit_cnt = 4'd0;
        lit_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sync2_q.an[i]) begin
                lit_cnt = lit_cnt + 4'd1;
                lit_idx = IW'(i);
            end
        end
    end

    assign one_lit   = capture && (lit_cnt == 4'd1);
    assign multi_lit = capture && (lit_cnt > 4'd1);

    seg7_to_hex u_seg7_to_hex (
        .seg   (sync2_q.seg),
        .value (dec_value),
        .legal (dec_legal),
        .blank (dec_blank)
    );

    assign dec_bad   = !dec_legal && !dec_blank;
    assign seen_next = seen_q | (NUM_DIGITS'(1) << lit_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q    <= '0;
            digit_valid <= '0;
            digit_blank <= '0;
            seen_q      <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (one_lit) begin
                if (dec_legal) begin
                    digits_q[lit_idx]    <= dec_value;
                    digit_valid[lit_idx] <= 1'b1;
                    digit_blank[lit_idx] <= 1'b0;
                end else if (dec_blank) begin
                    digits_q[lit_idx]    <= 4'd0;
                    digit_valid[lit_idx] <= 1'b0;
                    digit_blank[lit_idx] <= 1'b1;
                end else begin
                    digit_valid[lit_idx] <= 1'b0;
                    digit_blank[lit_idx] <= 1'b0;
                end
                if (&seen_next) begin
                    frame_done <= 1'b1;
                    seen_q     <= '0;
                end else begin
                    seen_q <= seen_next;
                end
            end
        end
    end

    assign digits = digits_q;

    // New errors take priority over a coincident clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_err  <= 1'b0;
            decode_err <= 1'b0;
        end else begin
            if (multi_lit) begin
                anode_err <= 1'b1;
            end else if (clr_err) begin
                anode_err <= 1'b0;
            end
            if (one_lit && dec_bad) begin
                decode_err <= 1'b1;
            end else if (clr_err) begin
                decode_err <= 1'b0;
            end
        end
    end

endmodule
